// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults, colour constants and pattern encodings
// for the vga_clk-domain pixel sources.
package vga_pkg;

    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BACK  = 48;
    localparam int VGA_H_VALID = 640;
    localparam int VGA_H_FRONT = 16;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BACK  = 33;
    localparam int VGA_V_VALID = 480;
    localparam int VGA_V_FRONT = 10;

    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] BLACK   = 24'h000000;
    localparam logic [23:0] GREY    = 24'h808080;

    localparam logic [1:0] PAT_BAR  = 2'd0;
    localparam logic [1:0] PAT_CHK  = 2'd1;
    localparam logic [1:0] PAT_GRAD = 2'd2;
    localparam logic [1:0] PAT_GREY = 2'd3;

    function automatic logic [23:0] bar_rgb(input logic [2:0] i);
        logic [23:0] c;
        case (i)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v raster counters with unregistered region decode; the caller
// registers these so sync, DE and pixel leave on the same cycle.
module vga_timing #(
    parameter int H_SYNC  = vga_pkg::VGA_H_SYNC,
    parameter int H_BACK  = vga_pkg::VGA_H_BACK,
    parameter int H_VALID = vga_pkg::VGA_H_VALID,
    parameter int H_FRONT = vga_pkg::VGA_H_FRONT,
    parameter int V_SYNC  = vga_pkg::VGA_V_SYNC,
    parameter int V_BACK  = vga_pkg::VGA_V_BACK,
    parameter int V_VALID = vga_pkg::VGA_V_VALID,
    parameter int V_FRONT = vga_pkg::VGA_V_FRONT
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    output logic       hs_act,
    output logic       vs_act,
    output logic       de,
    output logic       sof,
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam logic [9:0] HS   = 10'(H_SYNC);
    localparam logic [9:0] HA   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] HE   = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] HMAX = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
    localparam logic [9:0] VS   = 10'(V_SYNC);
    localparam logic [9:0] VA   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] VE   = 10'(V_SYNC + V_BACK + V_VALID);
    localparam logic [9:0] VMAX = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_de;
    logic       v_de;

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (h_cnt == HMAX) ? '0 : h_cnt + 10'd1;
            if (h_cnt == HMAX)
                v_cnt <= (v_cnt == VMAX) ? '0 : v_cnt + 10'd1;
        end
    end

    assign hs_act = h_cnt < HS;
    assign vs_act = v_cnt < VS;
    assign h_de   = (h_cnt >= HA) && (h_cnt < HE);
    assign v_de   = (v_cnt >= VA) && (v_cnt < VE);
    assign de     = h_de && v_de;
    assign sof    = (h_cnt == '0) && (v_cnt == '0);
    assign x      = de ? h_cnt - HA : '0;
    assign y      = de ? v_cnt - VA : '0;

endmodule

// File: rtl/vga_colorbar_gen.sv
// vga_colorbar_gen: VGA raster timing plus a frame-latched test pattern, all outputs
// registered together for hdmi_ctrl.
module vga_colorbar_gen
    import vga_pkg::*;
#(
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BACK   = VGA_H_BACK,
    parameter int   H_VALID  = VGA_H_VALID,
    parameter int   H_FRONT  = VGA_H_FRONT,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BACK   = VGA_V_BACK,
    parameter int   V_VALID  = VGA_V_VALID,
    parameter int   V_FRONT  = VGA_V_FRONT,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] pat_sel,
    output logic       hsync,
    output logic       vsync,
    output logic       rgb_valid,
    output logic [7:0] rgb_red,
    output logic [7:0] rgb_green,
    output logic [7:0] rgb_blue,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_start
);

    logic        hs_act;
    logic        vs_act;
    logic        de;
    logic        sof;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  pat_q;
    logic [7:0]  frame_cnt;
    logic [2:0]  bar;
    logic [23:0] pix;

    vga_timing #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_VALID(H_VALID), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_VALID(V_VALID), .V_FRONT(V_FRONT)
    ) u_timing (
        .vga_clk(vga_clk),
        .sys_rst_n(sys_rst_n),
        .hs_act(hs_act),
        .vs_act(vs_act),
        .de(de),
        .sof(sof),
        .x(x),
        .y(y)
    );

    // bar index by comparing against each bar boundary instead of dividing
    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++)
            if (x >= 10'(i * (H_VALID / 8))) bar = 3'(i);
    end

    always_comb
        pix = (pat_q == PAT_BAR)  ? bar_rgb(bar) :
              (pat_q == PAT_CHK)  ? ((x[5] ^ y[5]) ? WHITE : BLACK) :
              (pat_q == PAT_GRAD) ? {x[7:0], y[7:0], frame_cnt} : GREY;

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            pat_q       <= PAT_BAR;
            frame_cnt   <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            rgb_valid   <= 1'b0;
            {rgb_red, rgb_green, rgb_blue} <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            if (sof) begin
                pat_q     <= pat_sel;
                frame_cnt <= frame_cnt + 8'd1;
            end
            hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
            rgb_valid   <= de;
            {rgb_red, rgb_green, rgb_blue} <= de ? pix : '0;
            pix_x       <= x;
            pix_y       <= y;
            frame_start <= sof;
        end
    end

endmodule

// File: tb/tb_vga_colorbar_gen.sv
// tb_vga_colorbar_gen: two reduced-raster instances checked every cycle against an
// index-arithmetic model, plus literal pixel/count expectations.
module tb_vga_colorbar_gen;

    localparam int AHS = 4, AHB = 4, AHV = 80, AHF = 4, AVS = 2, AVB = 2, AVV = 40, AVF = 2;
    localparam int BHS = 2, BHB = 1, BHV = 8,  BHF = 1, BVS = 1, BVB = 1, BVV = 8,  BVF = 1;
    localparam int HT_A = AHS + AHB + AHV + AHF;
    localparam int FT_A = HT_A * (AVS + AVB + AVV + AVF);
    localparam int HT_B = BHS + BHB + BHV + BHF;
    localparam int FT_B = HT_B * (BVS + BVB + BVV + BVF);

    logic clk = 1'b0;
    logic rst_a = 1'b0, rst_b = 1'b0;
    logic [1:0] pat_a = 2'd0, pat_b = 2'd2;
    logic hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic [9:0] x_a, y_a, x_b, y_b;

    int checks = 0, errors = 0;
    int m_a = -1, m_b = -1;
    logic in_rst_a = 1'b1, in_rst_b = 1'b1;
    logic [1:0] patf_a = 2'd0, patf_b = 2'd0;
    logic [7:0] fc_a = 8'd0, fc_b = 8'd0;
    int n_hs = 0, n_hs1 = 0, n_vs = 0, n_de = 0;
    bit done_b = 0;

    always #5 clk = ~clk;

    vga_colorbar_gen #(
        .H_SYNC(AHS), .H_BACK(AHB), .H_VALID(AHV), .H_FRONT(AHF),
        .V_SYNC(AVS), .V_BACK(AVB), .V_VALID(AVV), .V_FRONT(AVF), .SYNC_POL(1'b1)
    ) u_a (
        .vga_clk(clk), .sys_rst_n(rst_a), .pat_sel(pat_a),
        .hsync(hs_a), .vsync(vs_a), .rgb_valid(de_a),
        .rgb_red(r_a), .rgb_green(g_a), .rgb_blue(b_a),
        .pix_x(x_a), .pix_y(y_a), .frame_start(fs_a)
    );

    vga_colorbar_gen #(
        .H_SYNC(BHS), .H_BACK(BHB), .H_VALID(BHV), .H_FRONT(BHF),
        .V_SYNC(BVS), .V_BACK(BVB), .V_VALID(BVV), .V_FRONT(BVF), .SYNC_POL(1'b1)
    ) u_b (
        .vga_clk(clk), .sys_rst_n(rst_b), .pat_sel(pat_b),
        .hsync(hs_b), .vsync(vs_b), .rgb_valid(de_b),
        .rgb_red(r_b), .rgb_green(g_b), .rgb_blue(b_b),
        .pix_x(x_b), .pix_y(y_b), .frame_start(fs_b)
    );

    // expected {hsync,vsync,de,rgb,pix_x,pix_y,frame_start} for output index m
    function automatic logic [47:0] model(int m, logic [1:0] p, logic [7:0] fc,
                                          int hs, int hb, int hv, int hf,
                                          int vs, int vb, int vv, int vf);
        int ht, vt, h, v, x, y;
        logic de;
        logic [23:0] c;
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        ht = hs + hb + hv + hf;
        vt = vs + vb + vv + vf;
        h = m % ht;
        v = (m / ht) % vt;
        de = (h >= hs + hb) && (h < hs + hb + hv) && (v >= vs + vb) && (v < vs + vb + vv);
        x = de ? h - hs - hb : 0;
        y = de ? v - vs - vb : 0;
        if (!de)         c = 24'h0;
        else if (p == 0) c = bars[x / (hv / 8)];
        else if (p == 1) c = (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        else if (p == 2) c = {8'(x % 256), 8'(y % 256), fc};
        else             c = 24'h808080;
        return {h < hs, v < vs, de, c, 10'(x), 10'(y), (h == 0) && (v == 0)};
    endfunction

    function automatic int pidx_a(int k, int x, int y);
        return k * FT_A + (y + AVS + AVB) * HT_A + x + AHS + AHB;
    endfunction

    function automatic int pidx_b(int k, int x, int y);
        return k * FT_B + (y + BVS + BVB) * HT_B + x + BHS + BHB;
    endfunction

    always @(posedge clk) begin
        if (!rst_a) begin
            m_a <= -1; in_rst_a <= 1'b1; fc_a <= 8'd0; patf_a <= 2'd0;
        end else begin
            in_rst_a <= 1'b0;
            m_a <= m_a + 1;
            if ((m_a + 1) % FT_A == 0) begin
                patf_a <= pat_a;
                fc_a <= fc_a + 8'd1;
            end
        end
        if (!rst_b) begin
            m_b <= -1; in_rst_b <= 1'b1; fc_b <= 8'd0; patf_b <= 2'd0;
        end else begin
            in_rst_b <= 1'b0;
            m_b <= m_b + 1;
            if ((m_b + 1) % FT_B == 0) begin
                patf_b <= pat_b;
                fc_b <= fc_b + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        logic [47:0] ea, eb, aa, ab;
        ea = in_rst_a ? 48'h0 : model(m_a, patf_a, fc_a, AHS, AHB, AHV, AHF, AVS, AVB, AVV, AVF);
        eb = in_rst_b ? 48'h0 : model(m_b, patf_b, fc_b, BHS, BHB, BHV, BHF, BVS, BVB, BVV, BVF);
        aa = {hs_a, vs_a, de_a, r_a, g_a, b_a, x_a, y_a, fs_a};
        ab = {hs_b, vs_b, de_b, r_b, g_b, b_b, x_b, y_b, fs_b};
        checks += 2;
        if (aa !== ea) begin
            errors++;
            if (errors < 20) $display("FAIL model_a idx=%0d got=%h want=%h", m_a, aa, ea);
        end
        if (ab !== eb) begin
            errors++;
            if (errors < 20) $display("FAIL model_b idx=%0d got=%h want=%h", m_b, ab, eb);
        end
        if (!in_rst_a && m_a >= 0 && m_a < FT_A) begin
            n_hs += int'(hs_a);
            n_vs += int'(vs_a);
            n_de += int'(de_a);
            if (m_a < HT_A) n_hs1 += int'(hs_a);
        end
    end

    task automatic lit(input string name, input logic [47:0] got, input logic [47:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_a(input int idx);
        while (m_a < idx) @(negedge clk);
    endtask

    task automatic wait_b(input int idx);
        while (m_b < idx) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (10) @(negedge clk);
        lit("rst_sync", {hs_a, vs_a, de_a}, 48'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        lit("first_fs_a", 48'(fs_a), 48'h1);
        lit("first_fs_b", 48'(fs_b), 48'h1);
        fork
            begin
                wait_a(pidx_a(0, 0, 0));
                lit("bar_x0", {r_a, g_a, b_a}, 48'hFFFFFF);
                wait_a(pidx_a(0, 10, 0));
                lit("bar_x10", {r_a, g_a, b_a}, 48'hFFFF00);
                wait_a(pidx_a(0, 79, 0));
                lit("bar_x79", {de_a, r_a, g_a, b_a}, 48'h1000000);
                wait_a(pidx_a(0, 79, 0) + 1);
                lit("blank_rgb", {de_a, r_a, g_a, b_a}, 48'h0);
                wait_a(FT_A);
                lit("hs_line", 48'(n_hs1), 48'd4);
                lit("hs_frame", 48'(n_hs), 48'd184);
                lit("vs_frame", 48'(n_vs), 48'd184);
                lit("de_frame", 48'(n_de), 48'd3200);
                wait_a(pidx_a(1, 50, 20));
                pat_a = 2'd1;
                wait_a(pidx_a(1, 60, 30));
                lit("bar_held", {r_a, g_a, b_a}, 48'h0000FF);
                wait_a(pidx_a(2, 32, 0));
                lit("chk_32_0", {r_a, g_a, b_a}, 48'hFFFFFF);
                wait_a(pidx_a(2, 32, 32));
                lit("chk_32_32", {r_a, g_a, b_a}, 48'h000000);
                pat_a = 2'd3;
                wait_a(pidx_a(3, 5, 5));
                lit("grey", {r_a, g_a, b_a}, 48'h808080);
                pat_a = 2'($urandom_range(0, 3));
                wait_a(pidx_a(4, 32, 26));
                rst_a = 1'b0;
                @(negedge clk);
                lit("mid_rst", {de_a, x_a, y_a}, 48'h0);
                repeat (2) @(negedge clk);
                rst_a = 1'b1;
                @(negedge clk);
                lit("restart_fs", 48'(fs_a), 48'h1);
                while (!done_b) begin
                    @(negedge clk);
                    if ($urandom_range(0, 299) == 0) pat_a = 2'($urandom_range(0, 3));
                end
            end
            begin
                for (int k = 0; k < 257; k++) begin
                    wait_b(pidx_b(k, 5, 7));
                    lit("grad_5_7", {r_b, g_b, b_b}, {24'h0, 8'h05, 8'h07, 8'(k + 1)});
                end
                done_b = 1;
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
